// File: rtl/ksa_pkg.sv
// rtl/ksa_pkg.sv - shared constants, sum type and round-robin pick helper
package ksa_pkg;

  localparam int KSA_WIDTH = 21;

  typedef logic [KSA_WIDTH:0] sum_t;

  // First set bit of valid searching ptr, ptr+1, ... modulo n (n <= 8).
  // Iterates from the farthest offset down so the nearest hit is written last.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                         input int n);
    logic [2:0] pick;
    int idx;
    pick = ptr;
    idx  = 0;
    for (int k = 7; k >= 0; k--) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx[2:0]]) pick = idx[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ksa_core.sv
// rtl/ksa_core.sv - combinational Kogge-Stone adder with carry-in and carry-out
import ksa_pkg::*;

module ksa_core #(
  parameter int WIDTH = KSA_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH:0]   s
);

  // Position 0 of the prefix tree is the carry-in, so the tree spans WIDTH+1 slots.
  localparam int LEVELS = $clog2(WIDTH + 1);

  // Carry operator cell: combine a high (g,p) span with the adjacent low span.
  function automatic logic [1:0] carry_op(input logic gh, input logic ph,
                                          input logic gl, input logic pl);
    return {gh | (ph & gl), ph & pl};
  endfunction

  logic [WIDTH:0] gc, pc, gn, pn;

  // GP generation, log-depth prefix tree, then sum XOR; gc[j] ends as carry into bit j.
  always_comb begin
    gc = {x & y, cin};
    pc = {x ^ y, 1'b0};
    gn = gc;
    pn = pc;
    for (int lv = 0; lv < LEVELS; lv++) begin
      gn = gc;
      pn = pc;
      for (int j = 0; j <= WIDTH; j++) begin
        if (j >= (1 << lv)) begin
          {gn[j], pn[j]} = carry_op(gc[j], pc[j], gc[j-(1<<lv)], pc[j-(1<<lv)]);
        end
      end
      gc = gn;
      pc = pn;
    end
    s = {gc[WIDTH], (x ^ y) ^ gc[WIDTH-1:0]};
  end

endmodule

// File: rtl/ksa_share_arbiter.sv
// rtl/ksa_share_arbiter.sv - round-robin sharing of one Kogge-Stone adder among N requesters
import ksa_pkg::*;

module ksa_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = KSA_WIDTH,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_x,
  input  logic [N_REQ*WIDTH-1:0] req_y,
  input  logic [N_REQ-1:0]       req_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH:0]         rsp_sum,
  output logic [ID_W-1:0]        rsp_id,
  output logic [15:0]            busy_cnt
);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  winner;
  logic [7:0]       vpad;
  logic [2:0]       ppad;
  logic [2:0]       pick;
  logic             can_accept;
  logic             any_valid;
  logic             stalled;
  logic [WIDTH-1:0] mux_x, mux_y;
  logic             mux_cin;
  logic [WIDTH:0]   core_s;

  assign can_accept = !rsp_valid | rsp_ready;
  assign any_valid  = |req_valid;
  assign stalled    = |(req_valid & ~req_ready);

  // Winner selection and one-hot grant; depends only on req_valid, pointer and output state.
  always_comb begin
    vpad = '0;
    vpad[N_REQ-1:0] = req_valid;
    ppad = '0;
    ppad[ID_W-1:0] = rr_ptr;
    pick = rr_pick(vpad, ppad, N_REQ);
    winner = pick[ID_W-1:0];
    req_ready = '0;
    if (!rst && can_accept && any_valid) req_ready[winner] = 1'b1;
  end

  // Steer the winner's operands onto the shared adder.
  always_comb begin
    mux_x   = '0;
    mux_y   = '0;
    mux_cin = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        mux_x   = req_x[i*WIDTH +: WIDTH];
        mux_y   = req_y[i*WIDTH +: WIDTH];
        mux_cin = req_cin[i];
      end
    end
  end

  ksa_core #(.WIDTH(WIDTH)) u_core (
    .x   (mux_x),
    .y   (mux_y),
    .cin (mux_cin),
    .s   (core_s)
  );

  // Output register and round-robin pointer; retire and reload happen on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (can_accept) begin
      rsp_valid <= any_valid;
      if (any_valid) begin
        rsp_sum <= core_s;
        rsp_id  <= winner;
        if (winner == ID_W'(N_REQ - 1)) rr_ptr <= '0;
        else                            rr_ptr <= winner + 1'b1;
      end
    end
  end

  // Saturating count of cycles in which at least one request waits.
  always_ff @(posedge clk) begin
    if (rst)                                busy_cnt <= '0;
    else if (stalled && busy_cnt != 16'hFFFF) busy_cnt <= busy_cnt + 16'd1;
  end

endmodule

// File: tb/tb_ksa_share_arbiter.sv
// tb/tb_ksa_share_arbiter.sv - directed vector table plus randomized model check of ksa_share_arbiter
module tb_ksa_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [83:0] req_x = '0;
  logic [83:0] req_y = '0;
  logic [3:0]  req_cin = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [21:0] rsp_sum;
  logic [1:0]  rsp_id;
  logic [15:0] busy_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ksa_share_arbiter #(.N_REQ(4), .WIDTH(21)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy_cnt  (busy_cnt)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [83:0] x;
    logic [83:0] y;
    logic [3:0]  cin;
    logic        rsp_rdy;
    logic        chk_regs;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [21:0] exp_sum;
    logic [1:0]  exp_id;
    logic [15:0] exp_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic [83:0] x, input logic [83:0] y,
                     input logic [3:0] c, input logic rr, input logic ck, input logic [3:0] er,
                     input logic ev, input logic [21:0] es, input logic [1:0] ei, input logic [15:0] eb);
    vec_t t;
    t.rst = r; t.valid = v; t.x = x; t.y = y; t.cin = c; t.rsp_rdy = rr;
    t.chk_regs = ck; t.exp_ready = er; t.exp_valid = ev; t.exp_sum = es; t.exp_id = ei; t.exp_busy = eb;
    tbl.push_back(t);
  endtask

  // Behavioural reference state
  int     m_ptr, m_busy, m_id;
  bit     m_pv;
  longint m_sum;
  bit     synced;

  initial begin
    logic [83:0] sx, mx;
    logic [20:0] xa[4], ya[4];
    logic [3:0]  exp_rdy;
    int          w;
    bit          found, can;
    longint      a, b, c;

    sx = {21'd3, 21'd2, 21'd1, 21'd0};
    mx = sx;
    mx[42 +: 21] = 21'h1FFFFF;

    //   rst  valid    x             y        cin      rr  chk ready    v  sum         id    busy
    add(1'b1, 4'b0000, sx,           sx,      4'b1111, 1, 0, 4'b0000, 0, 22'h0,      2'd0, 16'd0);
    add(1'b0, 4'b0001, 84'h1FFFFF,   84'h1,   4'b0000, 1, 1, 4'b0001, 0, 22'h0,      2'd0, 16'd0);
    add(1'b0, 4'b0000, sx,           sx,      4'b1111, 1, 1, 4'b0000, 1, 22'h200000, 2'd0, 16'd0);
    add(1'b0, 4'b1111, sx,           sx,      4'b1111, 1, 1, 4'b0010, 0, 22'h200000, 2'd0, 16'd0);
    add(1'b0, 4'b1111, sx,           sx,      4'b1111, 1, 1, 4'b0100, 1, 22'd3,      2'd1, 16'd1);
    add(1'b0, 4'b1111, sx,           sx,      4'b1111, 1, 1, 4'b1000, 1, 22'd5,      2'd2, 16'd2);
    add(1'b0, 4'b1111, sx,           sx,      4'b1111, 1, 1, 4'b0001, 1, 22'd7,      2'd3, 16'd3);
    add(1'b0, 4'b1111, sx,           sx,      4'b1111, 1, 1, 4'b0010, 1, 22'd1,      2'd0, 16'd4);
    add(1'b0, 4'b1111, sx,           sx,      4'b1111, 1, 1, 4'b0100, 1, 22'd3,      2'd1, 16'd5);
    add(1'b0, 4'b1111, sx,           sx,      4'b1111, 1, 1, 4'b1000, 1, 22'd5,      2'd2, 16'd6);
    add(1'b0, 4'b1001, sx,           sx,      4'b1111, 1, 1, 4'b0001, 1, 22'd7,      2'd3, 16'd7);
    add(1'b0, 4'b1001, sx,           sx,      4'b1111, 1, 1, 4'b1000, 1, 22'd1,      2'd0, 16'd8);
    add(1'b0, 4'b0100, mx,           mx,      4'b1111, 1, 1, 4'b0100, 1, 22'd7,      2'd3, 16'd9);
    add(1'b0, 4'b0010, sx,           sx,      4'b1111, 0, 1, 4'b0000, 1, 22'h3FFFFF, 2'd2, 16'd9);
    add(1'b0, 4'b0010, sx,           sx,      4'b1111, 0, 1, 4'b0000, 1, 22'h3FFFFF, 2'd2, 16'd10);
    add(1'b0, 4'b0010, sx,           sx,      4'b1111, 0, 1, 4'b0000, 1, 22'h3FFFFF, 2'd2, 16'd11);
    add(1'b0, 4'b0010, sx,           sx,      4'b1111, 1, 1, 4'b0010, 1, 22'h3FFFFF, 2'd2, 16'd12);
    add(1'b0, 4'b1111, sx,           sx,      4'b1111, 1, 1, 4'b0100, 1, 22'd3,      2'd1, 16'd12);
    add(1'b1, 4'b1111, sx,           sx,      4'b1111, 1, 1, 4'b0000, 1, 22'd5,      2'd2, 16'd13);
    add(1'b0, 4'b0110, sx,           sx,      4'b1111, 1, 1, 4'b0010, 0, 22'd0,      2'd0, 16'd0);
    add(1'b0, 4'b0000, sx,           sx,      4'b1111, 1, 1, 4'b0000, 1, 22'd3,      2'd1, 16'd1);

    foreach (tbl[k]) begin
      @(negedge clk);
      rst = tbl[k].rst; req_valid = tbl[k].valid; req_x = tbl[k].x; req_y = tbl[k].y;
      req_cin = tbl[k].cin; rsp_ready = tbl[k].rsp_rdy;
      #1;
      chk($sformatf("tbl%0d req_ready", k), 32'(req_ready), 32'(tbl[k].exp_ready));
      if (tbl[k].chk_regs) begin
        chk($sformatf("tbl%0d rsp_valid", k), 32'(rsp_valid), 32'(tbl[k].exp_valid));
        chk($sformatf("tbl%0d rsp_sum", k),   32'(rsp_sum),   32'(tbl[k].exp_sum));
        chk($sformatf("tbl%0d rsp_id", k),    32'(rsp_id),    32'(tbl[k].exp_id));
        chk($sformatf("tbl%0d busy_cnt", k),  32'(busy_cnt),  32'(tbl[k].exp_busy));
      end
    end

    // Randomized traffic against the reference model; first cycle resets both sides.
    synced = 0;
    m_ptr = 0; m_busy = 0; m_id = 0; m_pv = 0; m_sum = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      rst = (cyc == 0) || ($urandom_range(0, 79) == 0);
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        xa[i] = ($urandom_range(0, 7) == 0) ? 21'h1FFFFF : 21'($urandom);
        ya[i] = ($urandom_range(0, 7) == 0) ? 21'h1FFFFF : 21'($urandom);
        req_x[i*21 +: 21] = xa[i];
        req_y[i*21 +: 21] = ya[i];
      end
      req_cin = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;

      can = !m_pv || rsp_ready;
      found = 0;
      w = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && req_valid[(m_ptr + k) % 4]) begin
          found = 1;
          w = (m_ptr + k) % 4;
        end
      end
      exp_rdy = (!rst && can && found) ? 4'(1 << w) : 4'b0000;

      chk("rnd req_ready", 32'(req_ready), 32'(exp_rdy));
      if (synced) begin
        chk("rnd rsp_valid", 32'(rsp_valid), 32'(m_pv));
        chk("rnd rsp_sum",   32'(rsp_sum),   32'(m_sum));
        chk("rnd rsp_id",    32'(rsp_id),    32'(m_id));
        chk("rnd busy_cnt",  32'(busy_cnt),  32'(m_busy));
      end

      if (rst) begin
        m_ptr = 0; m_busy = 0; m_id = 0; m_pv = 0; m_sum = 0;
      end else begin
        if ((req_valid & ~exp_rdy) != 4'b0000 && m_busy < 65535) m_busy++;
        if (can) begin
          if (found) begin
            a = longint'(xa[w]); b = longint'(ya[w]); c = longint'(req_cin[w]);
            m_sum = a + b + c;
            m_id  = w;
            m_pv  = 1;
            m_ptr = (w + 1) % 4;
          end else begin
            m_pv = 0;
          end
        end
      end
      synced = 1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
